// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and the stage record type.
// No logic of its own; imported by the delay line and its stages.
// No flow control involved.
package riscv_pipe_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int XLEN       = 32;

  // One pipeline slot: a payload plus the bit saying whether it is live.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] data;
  } stage_t;

endpackage

// File: rtl/pipe_stage.sv
// One delay-line slot: register with synchronous reset, hold, kill and bubble-zero.
// Latency: 1 cycle from vld_i/dat_i to valid_o/data_o.
// Backpressure: stall_i holds the slot; flush_i clears it even while stalled.
module pipe_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             flush_i,
  input  logic             vld_i,
  input  logic [WIDTH-1:0] dat_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  // Next slot contents: shift in (bubbles carry zero), else hold on stall; kill wins over both.
  always_comb begin
    valid_d = vld_i;
    data_d  = vld_i ? dat_i : '0;
    if (stall_i) begin
      valid_d = valid_q;
      data_d  = data_q;
    end
    if (flush_i) begin
      valid_d = 1'b0;
      data_d  = '0;
    end
  end

  // Slot register; reset overrides stall and flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_delay_line.sv
// Stallable, flushable DEPTH-stage delay line exposing every stage, occupancy and address match.
// Latency: DEPTH cycles input to out_*, plus one per stall cycle; outputs depend only on stage regs (and query).
// Backpressure: none beyond stall; the oldest entry is dropped when it leaves the last stage.
module pipe_delay_line
  import riscv_pipe_pkg::*;
#(
  parameter int WIDTH         = XLEN,
  parameter int DEPTH         = 3,
  parameter int MATCH_W       = REG_ADDR_W,
  parameter bit ZERO_NO_MATCH = 1'b1,
  localparam int OCC_W        = $clog2(DEPTH + 1),
  localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic [DEPTH-1:0]       flush,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic [OCC_W-1:0]       occupancy,
  input  logic [MATCH_W-1:0]     query,
  output logic [DEPTH-1:0]       match_vec,
  output logic                   match_any,
  output logic [IDX_W-1:0]       match_idx
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] dat_q [DEPTH];

  // Stage 0 is fed from the input; every later stage from its younger neighbour.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic             src_vld;
    logic [WIDTH-1:0] src_dat;
    if (i == 0) begin : g_head
      assign src_vld = in_valid;
      assign src_dat = in_data;
    end else begin : g_body
      assign src_vld = vld_q[i-1];
      assign src_dat = dat_q[i-1];
    end

    pipe_stage #(.WIDTH(WIDTH)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .stall_i (stall),
      .flush_i (flush[i]),
      .vld_i   (src_vld),
      .dat_i   (src_dat),
      .valid_o (vld_q[i]),
      .data_o  (dat_q[i])
    );

    assign stage_data[i*WIDTH +: WIDTH] = dat_q[i];
  end

  assign stage_valid = vld_q;
  assign out_valid   = vld_q[DEPTH-1];
  assign out_data    = dat_q[DEPTH-1];

  // Popcount of live stages.
  always_comb begin
    occupancy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occupancy = occupancy + OCC_W'(vld_q[i]);
    end
  end

  // Hazard match on low payload bits; a zero query (x0) can be made never to hit.
  always_comb begin
    match_vec = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_vec[i] = vld_q[i] && (dat_q[i][MATCH_W-1:0] == query);
    end
    if (ZERO_NO_MATCH && (query == '0)) begin
      match_vec = '0;
    end
  end

  // Youngest hit wins: scan oldest to youngest so the lowest index is written last.
  always_comb begin
    match_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_vec[i]) begin
        match_idx = IDX_W'(i);
      end
    end
  end

  assign match_any = |match_vec;

endmodule

// File: tb/tb_pipe_delay_line.sv
// Scoreboard bench for pipe_delay_line: directed scenarios followed by random traffic.
// A queue-of-slots reference model predicts every output; a negedge monitor compares.
// Stall and flush are driven randomly during the random phase.
module tb_pipe_delay_line;

  localparam int W  = 32;
  localparam int D  = 3;
  localparam int MW = 5;
  localparam int OW = 2;
  localparam int IW = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall;
  logic [D-1:0]     flush;
  logic             in_valid;
  logic [W-1:0]     in_data;
  logic [MW-1:0]    query;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [D-1:0]     stage_valid;
  logic [D*W-1:0]   stage_data;
  logic [OW-1:0]    occupancy;
  logic [D-1:0]     match_vec;
  logic             match_any;
  logic [IW-1:0]    match_idx;

  always #5 clk = ~clk;

  pipe_delay_line #(.WIDTH(W), .DEPTH(D), .MATCH_W(MW), .ZERO_NO_MATCH(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy),
    .query       (query),
    .match_vec   (match_vec),
    .match_any   (match_any),
    .match_idx   (match_idx)
  );

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } ent_t;

  typedef struct {
    logic           ov;
    logic [W-1:0]   od;
    logic [D-1:0]   sv;
    logic [D*W-1:0] sd;
    int             occ;
    logic [D-1:0]   mv;
    logic           ma;
    int             mi;
  } exp_t;

  ent_t model[$];   // index 0 = youngest slot
  exp_t sb[$];
  bit   model_ok = 1'b0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the slot list plus the current query.
  function automatic exp_t predict(input logic [MW-1:0] q);
    exp_t e;
    bit   found;
    e.occ = 0;
    e.mv  = '0;
    e.mi  = 0;
    e.sv  = '0;
    e.sd  = '0;
    found = 1'b0;
    for (int i = 0; i < D; i++) begin
      e.sv[i]         = model[i].v;
      e.sd[i*W +: W]  = model[i].d;
      if (model[i].v) e.occ++;
      if (model[i].v && q != 0 && model[i].d[MW-1:0] == q) begin
        e.mv[i] = 1'b1;
        if (!found) begin
          e.mi  = i;
          found = 1'b1;
        end
      end
    end
    e.ma = found;
    e.ov = model[D-1].v;
    e.od = model[D-1].d;
    return e;
  endfunction

  // Advance the reference model by one clock edge.
  task automatic model_edge(input bit r, input bit s, input logic [D-1:0] f,
                            input bit iv, input logic [W-1:0] id);
    ent_t z;
    z = '0;
    if (r) begin
      model = {};
      for (int i = 0; i < D; i++) model.push_back(z);
      return;
    end
    if (!s) begin
      ent_t n;
      n.v = iv;
      n.d = iv ? id : '0;
      model.push_front(n);
      void'(model.pop_back());
    end
    for (int i = 0; i < D; i++) if (f[i]) model[i] = z;
  endtask

  // Drive one cycle of inputs, record the expectation for this cycle, then take the edge.
  task automatic step(input bit r, input bit s, input logic [D-1:0] f,
                      input bit iv, input logic [W-1:0] id, input logic [MW-1:0] q);
    reset    = r;
    stall    = s;
    flush    = f;
    in_valid = iv;
    in_data  = id;
    query    = q;
    if (model_ok) sb.push_back(predict(q));
    @(posedge clk);
    model_edge(r, s, f, iv, id);
    if (r) model_ok = 1'b1;
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, 1'b0, 32'hDEAD_BEEF, 5'd0);
  endtask

  // Monitor: compare DUT outputs against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("out_valid",   128'(out_valid),   128'(e.ov));
        check("out_data",    128'(out_data),    128'(e.od));
        check("stage_valid", 128'(stage_valid), 128'(e.sv));
        check("stage_data",  128'(stage_data),  128'(e.sd));
        check("occupancy",   128'(occupancy),   128'(e.occ));
        check("match_vec",   128'(match_vec),   128'(e.mv));
        check("match_any",   128'(match_any),   128'(e.ma));
        check("match_idx",   128'(match_idx),   128'(e.mi));
      end
    end
  end

  initial begin
    for (int i = 0; i < D; i++) model.push_back('0);
    reset = 1'b1; stall = 1'b0; flush = '0; in_valid = 1'b0; in_data = '0; query = '0;

    step(1'b1, 1'b0, '0, 1'b0, '0, 5'd0);
    step(1'b1, 1'b0, '0, 1'b0, '0, 5'd0);
    check("reset_out_valid", 128'(out_valid), 128'(0));
    check("reset_occ",       128'(occupancy), 128'(0));

    // Fill A, B, C: A reaches the output three edges after it was driven.
    step(1'b0, 1'b0, '0, 1'b1, 32'hA, 5'd0);
    check("ramp_occ1", 128'(occupancy), 128'(1));
    step(1'b0, 1'b0, '0, 1'b1, 32'hB, 5'd0);
    check("ramp_occ2", 128'(occupancy), 128'(2));
    step(1'b0, 1'b0, '0, 1'b1, 32'hC, 5'd0);
    check("latency_valid", 128'(out_valid), 128'(1));
    check("latency_data",  128'(out_data),  128'(32'hA));
    check("ramp_occ3",     128'(occupancy), 128'(3));

    // Two stall cycles with junk input: A held on the output.
    step(1'b0, 1'b1, '0, 1'b1, 32'h1234_5678, 5'd0);
    step(1'b0, 1'b1, '0, 1'b1, 32'h8765_4321, 5'd0);
    check("stall_hold_out", 128'(out_data),   128'(32'hA));
    check("stall_hold_all", 128'(stage_data), 128'({32'hA, 32'hB, 32'hC}));
    step(1'b0, 1'b0, '0, 1'b0, '0, 5'd0);
    check("after_stall_out", 128'(out_data), 128'(32'hB));
    idle(3);

    // Kill stages 0 and 1 while shifting.
    step(1'b0, 1'b0, '0, 1'b1, 32'h1, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h2, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h3, 5'd0);
    step(1'b0, 1'b0, 3'b011, 1'b1, 32'h4, 5'd0);
    check("flush_valid", 128'(stage_valid), 128'(3'b100));
    check("flush_data",  128'(stage_data),  128'({32'h2, 32'h0, 32'h0}));
    check("flush_occ",   128'(occupancy),   128'(1));

    // Same kill during a stall: oldest holds its own value.
    step(1'b0, 1'b0, '0, 1'b1, 32'h1, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h2, 5'd0);
    step(1'b0, 1'b0, '0, 1'b1, 32'h3, 5'd0);
    step(1'b0, 1'b1, 3'b011, 1'b1, 32'h4, 5'd0);
    check("flush_stall_valid", 128'(stage_valid), 128'(3'b100));
    check("flush_stall_data",  128'(stage_data),  128'({32'h1, 32'h0, 32'h0}));

    // Register-address match: stages {5,7,5}, youngest hit reported.
    step(1'b0, 1'b0, '0, 1'b1, 32'h5, 5'd5);
    step(1'b0, 1'b0, '0, 1'b1, 32'h7, 5'd5);
    step(1'b0, 1'b0, '0, 1'b1, 32'h5, 5'd5);
    check("match_vec_575", 128'(match_vec), 128'(3'b101));
    check("match_idx_575", 128'(match_idx), 128'(0));
    step(1'b0, 1'b0, '0, 1'b1, 32'h20, 5'd0);
    check("zero_query_no_match", 128'(match_any), 128'(0));

    // Bubble between two payloads carries zero data.
    step(1'b0, 1'b0, '0, 1'b1, 32'h1, 5'd5);
    step(1'b0, 1'b0, '0, 1'b0, 32'hFFFF_FFE5, 5'd5);
    step(1'b0, 1'b0, '0, 1'b1, 32'h2, 5'd5);
    check("bubble_valid", 128'(stage_valid[1]),      128'(0));
    check("bubble_data",  128'(stage_data[63:32]),   128'(0));
    check("bubble_match", 128'(match_vec[1]),        128'(0));

    // Reset while full and stalled, then first input emerges after DEPTH edges.
    step(1'b0, 1'b0, '0, 1'b1, 32'h11, 5'd0);
    step(1'b1, 1'b1, 3'b010, 1'b1, 32'h12, 5'd0);
    check("midreset_valid", 128'(stage_valid), 128'(0));
    check("midreset_data",  128'(stage_data),  128'(0));
    step(1'b0, 1'b0, '0, 1'b1, 32'hA1, 5'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 5'd0);
    step(1'b0, 1'b0, '0, 1'b0, '0, 5'd0);
    check("post_reset_out", 128'({out_valid, out_data}), 128'({1'b1, 32'hA1}));

    // Random traffic with small address values so matches are frequent.
    for (int n = 0; n < 400; n++) begin
      logic [W-1:0]  d;
      logic [D-1:0]  f;
      d = $urandom;
      d[MW-1:0] = MW'($urandom_range(0, 7));
      for (int b = 0; b < D; b++) f[b] = ($urandom_range(0, 9) == 0);
      step(($urandom_range(0, 79) == 0), ($urandom_range(0, 4) == 0), f,
           ($urandom_range(0, 9) < 7), d, MW'($urandom_range(0, 7)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drain", 128'(sb.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
